// File: rtl/data_ram_ctrl.sv
// Data-memory responder: serialises word/half/byte accesses from the core onto a
// byte-wide synchronous-read RAM, with a busy/done handshake for stalling.
module data_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  re,
  input  logic [31:0]           raddr,
  input  logic                  we,
  input  logic [31:0]           waddr,
  input  logic [31:0]           wdata,
  input  logic [1:0]            size,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din
);

  typedef enum logic [1:0] {IDLE, RD, RD_LAST, WR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, last, last_in;
  logic [23:0] wbuf, rbuf;
  logic        accept_wr, accept_rd;

  assign last_in = (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;

  generate
    if (ADDR_WIDTH < 32) begin : g_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^{raddr[31:ADDR_WIDTH], waddr[31:ADDR_WIDTH]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state)
      IDLE: begin
        if (ce && we) begin
          accept_wr = 1'b1;
          state_nxt = WR;
        end else if (ce && re) begin
          accept_rd = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        busy = 1'b1;
        if (cnt == last) state_nxt = RD_LAST;
      end
      RD_LAST: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      WR: begin
        busy = 1'b1;
        if (cnt == last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      last     <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
      rdata    <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_wr) begin
            mem_a    <= waddr[ADDR_WIDTH-1:0];
            mem_dout <= wdata[7:0];
            wbuf     <= wdata[31:8];
            mem_wr   <= 1'b1;
            cnt      <= '0;
            last     <= last_in;
          end else if (accept_rd) begin
            mem_a <= raddr[ADDR_WIDTH-1:0];
            cnt   <= '0;
            last  <= last_in;
          end
        end
        WR: begin
          if (cnt == last) begin
            mem_wr <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt      <= cnt + 2'd1;
            mem_a    <= mem_a + ADDR_WIDTH'(1);
            mem_dout <= wbuf[7:0];
            wbuf     <= {8'h00, wbuf[23:8]};
          end
        end
        RD: begin
          // RAM output lags the address by one cycle, so cnt-1 is the byte arriving now
          case (cnt)
            2'd1:    rbuf[7:0]   <= mem_din;
            2'd2:    rbuf[15:8]  <= mem_din;
            2'd3:    rbuf[23:16] <= mem_din;
            default: ;
          endcase
          if (cnt != last) begin
            cnt   <= cnt + 2'd1;
            mem_a <= mem_a + ADDR_WIDTH'(1);
          end
        end
        RD_LAST: begin
          cnt <= '0;
          case (last)
            2'd0:    rdata <= {24'h000000, mem_din};
            2'd1:    rdata <= {16'h0000, mem_din, rbuf[7:0]};
            default: rdata <= {mem_din, rbuf};
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: behavioural byte RAM, write/read scoreboards
// and per-cycle checks of the bus handshake.
module tb_data_ram_ctrl;

  localparam int unsigned AW = 17;
  localparam logic [AW-1:0] MASK = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0, re = 1'b0, we = 1'b0;
  logic [31:0]   raddr = '0, waddr = '0, wdata = '0;
  logic [1:0]    size = '0;
  logic [31:0]   rdata;
  logic          busy, done;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout;
  logic          mem_wr;
  logic [7:0]    mem_din = '0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [7:0]  ram    [0:(1<<AW)-1];
  logic [7:0]  shadow [0:(1<<AW)-1];
  logic [31:0] last_rdata = '0;

  data_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .re(re), .raddr(raddr), .we(we),
    .waddr(waddr), .wdata(wdata), .size(size), .rdata(rdata), .busy(busy),
    .done(done), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] <= mem_dout;
    mem_din <= ram[mem_a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic with_re);
    int n;
    wr_t e, got;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) begin
      e.a = AW'(a + 32'(i)) & MASK;
      e.d = d[8*i +: 8];
      wq.push_back(e);
      shadow[e.a] = e.d;
    end
    @(negedge clk);
    ce = 1'b1; we = 1'b1; re = with_re; waddr = a; wdata = d; size = sz;
    raddr = 32'h100;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; re = 1'b0;
    waddr = $urandom; wdata = $urandom; size = 2'($urandom);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("wr_busy", 32'(busy), 32'd1);
      check("wr_strobe", 32'(mem_wr), 32'd1);
      check("wr_done", 32'(done), 32'(k == n));
      got = wq.pop_front();
      check("wr_addr", 32'(mem_a), 32'(got.a));
      check("wr_byte", 32'(mem_dout), 32'(got.d));
    end
    @(negedge clk);
    check("wr_idle_busy", 32'(busy), 32'd0);
    check("wr_idle_strobe", 32'(mem_wr), 32'd0);
    check("wr_rdata_kept", rdata, last_rdata);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz);
    int n;
    logic [31:0] exp;
    n = nbytes(sz);
    exp = '0;
    for (int i = 0; i < n; i++) exp[8*i +: 8] = shadow[AW'(a + 32'(i)) & MASK];
    rq.push_back(exp);
    @(negedge clk);
    ce = 1'b1; re = 1'b1; raddr = a; size = sz;
    @(posedge clk);
    #1;
    ce = 1'b0; re = 1'b0; raddr = $urandom; size = 2'($urandom);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      check("rd_busy", 32'(busy), 32'd1);
      check("rd_no_strobe", 32'(mem_wr), 32'd0);
      check("rd_done", 32'(done), 32'(k == n + 1));
      if (k <= n) check("rd_addr", 32'(mem_a), 32'(AW'(a + 32'(k - 1)) & MASK));
      check("rd_rdata_hold", rdata, last_rdata);
    end
    @(negedge clk);
    check("rd_idle_busy", 32'(busy), 32'd0);
    last_rdata = rq.pop_front();
    check("rd_data", rdata, last_rdata);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 8'h00;
      shadow[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    rst = 1'b0;

    do_write(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0);
    do_read (32'h0000_0100, 2'b10);
    do_read (32'h0000_0102, 2'b00);
    do_read (32'h0000_0101, 2'b01);
    do_write(32'h0000_0010, 32'h1122_3344, 2'b00, 1'b1);
    do_read (32'h0000_0010, 2'b11);
    do_write(32'h5A01_FFFE, 32'h0123_4567, 2'b10, 1'b0);
    do_read (32'h0001_FFFE, 2'b10);
    do_write(32'h0000_0301, 32'h0000_A55A, 2'b01, 1'b0);
    do_read (32'h0000_0300, 2'b10);

    // Reset in cycle 2 of a word write: only byte 0 may reach the RAM
    ram[17'h201] = 8'h5A; ram[17'h202] = 8'h5A; ram[17'h203] = 8'h5A;
    shadow[17'h200] = 8'h0D;
    shadow[17'h201] = 8'h5A; shadow[17'h202] = 8'h5A; shadow[17'h203] = 8'h5A;
    @(negedge clk);
    ce = 1'b1; we = 1'b1; waddr = 32'h200; wdata = 32'hCAFE_F00D; size = 2'b10;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
    @(negedge clk);
    check("abort_c1_strobe", 32'(mem_wr), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_strobe", 32'(mem_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdata", rdata, 32'h0);
    last_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_byte0", 32'(ram[17'h200]), 32'h0D);
    check("abort_byte1", 32'(ram[17'h201]), 32'h5A);
    do_read(32'h0000_0200, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
